// File: rtl/serial_cmp_pkg.sv
// Shared types and merge rules for the framed serial comparator.
// A word's running result is a cmp_res_t updated once per accepted digit.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_GT = 2'b10
    } cmp_res_t;

    // Most significant digit first: the first differing digit decides.
    function automatic cmp_res_t merge_msb(input cmp_res_t prior, input cmp_res_t digit);
        return (prior == CMP_EQ) ? digit : prior;
    endfunction

    // Least significant digit first: any later differing digit overrides.
    function automatic cmp_res_t merge_lsb(input cmp_res_t prior, input cmp_res_t digit);
        return (digit != CMP_EQ) ? digit : prior;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_digit_cmp.sv
// Combinational compare of one digit pair; invert_msb turns the unsigned
// compare into a two's-complement compare for the sign digit.
module serial_digit_cmp
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               invert_msb,
    output cmp_res_t           res
);

    logic [DIGIT_W-1:0] a_x;
    logic [DIGIT_W-1:0] b_x;

    always_comb begin
        a_x = a;
        b_x = b;
        a_x[DIGIT_W-1] = a[DIGIT_W-1] ^ invert_msb;
        b_x[DIGIT_W-1] = b[DIGIT_W-1] ^ invert_msb;
        if (a_x < b_x) begin
            res = CMP_LT;
        end else if (a_x > b_x) begin
            res = CMP_GT;
        end else begin
            res = CMP_EQ;
        end
    end

endmodule

// File: rtl/serial_comparator_framed.sv
// Framed serial magnitude comparator: N_DIGITS digits per word, valid-qualified,
// registered one-hot result with a one-cycle out_valid strobe per word.
module serial_comparator_framed
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W   = 1,
    parameter int N_DIGITS  = 8,
    parameter int MSB_FIRST = 1,
    parameter int SIGNED    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic               busy,
    output logic               out_valid,
    output logic               a_less_b,
    output logic               a_eq_b,
    output logic               a_greater_b
);

    localparam int             CNT_W    = cnt_width(N_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);
    localparam bit             SIGN_ON  = (SIGNED != 0);
    localparam bit             MSB_ON   = (MSB_FIRST != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_eq_q, run_eq_d;
    logic             run_lt_q, run_lt_d;
    logic             out_valid_q, out_valid_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic     first;
    logic     last;
    logic     sign_beat;
    cmp_res_t digit_res;
    cmp_res_t prior;
    cmp_res_t new_res;

    assign first     = (cnt_q == '0);
    assign last      = (cnt_q == LAST_CNT);
    // The sign digit is the most significant one, whichever end it arrives on.
    assign sign_beat = SIGN_ON && (MSB_ON ? first : last);

    serial_digit_cmp #(
        .DIGIT_W(DIGIT_W)
    ) u_digit_cmp (
        .a          (a_digit),
        .b          (b_digit),
        .invert_msb (sign_beat),
        .res        (digit_res)
    );

    always_comb begin
        prior = CMP_EQ;
        if (!first) begin
            if (run_eq_q) begin
                prior = CMP_EQ;
            end else if (run_lt_q) begin
                prior = CMP_LT;
            end else begin
                prior = CMP_GT;
            end
        end
    end

    generate
        if (MSB_ON) begin : g_msb_first
            assign new_res = merge_msb(prior, digit_res);
        end else begin : g_lsb_first
            assign new_res = merge_lsb(prior, digit_res);
        end
    endgenerate

    always_comb begin
        cnt_d       = cnt_q;
        run_eq_d    = run_eq_q;
        run_lt_d    = run_lt_q;
        out_valid_d = 1'b0;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        if (in_valid) begin
            if (last) begin
                cnt_d       = '0;
                run_eq_d    = 1'b1;
                run_lt_d    = 1'b0;
                out_valid_d = 1'b1;
                lt_d        = (new_res == CMP_LT);
                eq_d        = (new_res == CMP_EQ);
                gt_d        = (new_res == CMP_GT);
            end else begin
                cnt_d    = cnt_q + 1'b1;
                run_eq_d = (new_res == CMP_EQ);
                run_lt_d = (new_res == CMP_LT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            run_eq_q    <= 1'b1;
            run_lt_q    <= 1'b0;
            out_valid_q <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            run_eq_q    <= run_eq_d;
            run_lt_q    <= run_lt_d;
            out_valid_q <= out_valid_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
        end
    end

    assign busy        = (cnt_q != '0);
    assign out_valid   = out_valid_q;
    assign a_less_b    = lt_q;
    assign a_eq_b      = eq_q;
    assign a_greater_b = gt_q;

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Scoreboard bench: several parameterisations run side by side, each with a
// driver pushing word-level expected results and a monitor popping on out_valid.
module tb_serial_comparator_framed;

    localparam int NCFG = 7;
    localparam int CW[NCFG] = '{1, 4, 1, 1, 3, 2, 3};
    localparam int CN[NCFG] = '{8, 2, 8, 8, 1, 3, 2};
    localparam int CM[NCFG] = '{1, 0, 1, 0, 1, 0, 1};
    localparam int CS[NCFG] = '{0, 0, 1, 1, 0, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run  = 0;
    int tests_fail = 0;
    int done_count = 0;

    task automatic check(input int cfg, input string nm, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_fail++;
            $display("FAIL cfg%0d %s: got %0d, expected %0d at %0t", cfg, nm, act, req, $time);
        end
    endtask

    // Expected-result code to {lt,eq,gt}; -1 means "no result yet".
    function automatic int code2flags(input int code);
        case (code)
            0:       return 3'b010;
            1:       return 3'b100;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W  = CW[gi];
        localparam int N  = CN[gi];
        localparam int M  = CM[gi];
        localparam int S  = CS[gi];
        localparam int WW = W * N;

        logic         rst_l    = 1'b1;
        logic         in_valid = 1'b0;
        logic [W-1:0] a_digit  = '0;
        logic [W-1:0] b_digit  = '0;
        logic         busy, out_valid, lt, eq, gt;
        int           exp_q[$];

        serial_comparator_framed #(
            .DIGIT_W  (W),
            .N_DIGITS (N),
            .MSB_FIRST(M),
            .SIGNED   (S)
        ) dut (
            .clk        (clk),
            .rst        (rst_l),
            .in_valid   (in_valid),
            .a_digit    (a_digit),
            .b_digit    (b_digit),
            .busy       (busy),
            .out_valid  (out_valid),
            .a_less_b   (lt),
            .a_eq_b     (eq),
            .a_greater_b(gt)
        );

        // Reference: interpret whole words as integers and compare them.
        function automatic int model(input longint unsigned wa, input longint unsigned wb);
            longint va, vb;
            va = longint'(wa);
            vb = longint'(wb);
            if (S != 0 && wa[WW-1]) va = va - (longint'(1) << WW);
            if (S != 0 && wb[WW-1]) vb = vb - (longint'(1) << WW);
            if (va < vb) return 1;
            if (va > vb) return 2;
            return 0;
        endfunction

        task automatic beat(input logic [W-1:0] da, input logic [W-1:0] db);
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a_digit  = da;
            b_digit  = db;
        endtask

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                a_digit  = W'($urandom);
                b_digit  = W'($urandom);
            end
        endtask

        task automatic send_word(input longint unsigned wa, input longint unsigned wb,
                                 input int maxgap, input int nbeats);
            for (int k = 0; k < nbeats; k++) begin
                int idx;
                idx = (M != 0) ? (N - 1 - k) : k;
                if (k > 0 && maxgap > 0) idle($urandom_range(0, maxgap));
                beat(W'(wa >> (W * idx)), W'(wb >> (W * idx)));
                if (k == N - 1) exp_q.push_back(model(wa, wb));
            end
        endtask

        function automatic longint unsigned rand_b(input longint unsigned wa);
            longint unsigned mask, wb;
            int mode;
            mask = (longint'(1) << WW) - 1;
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                wb = wa;
            end else if (mode == 1) begin
                wb = wa ^ (longint'($urandom_range(1, (1 << W) - 1)) << (W * $urandom_range(0, N - 1)));
            end else begin
                wb = longint'($urandom) & mask;
            end
            return wb & mask;
        endfunction

        // Monitor: pops one expectation per strobe, checks flags hold otherwise.
        initial begin
            bit rst_pend;
            int held;
            rst_pend = 1'b1;
            held     = -1;
            forever begin
                @(negedge clk);
                if (rst_pend) begin
                    check(gi, "rst_out_valid", int'(out_valid), 0);
                    check(gi, "rst_flags", int'({lt, eq, gt}), 0);
                    check(gi, "rst_busy", int'(busy), 0);
                    held = -1;
                    exp_q.delete();
                end else if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check(gi, "unexpected_out_valid", 1, 0);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        check(gi, "result_flags", int'({lt, eq, gt}), code2flags(e));
                        held = e;
                    end
                end else begin
                    check(gi, "held_flags", int'({lt, eq, gt}), code2flags(held));
                end
                rst_pend = rst_l;
            end
        end

        // Driver
        initial begin
            longint unsigned mask, wa, wb;
            longint unsigned da[6];
            longint unsigned db[6];
            da = '{64'h80, 64'hFF, 64'h3A, 64'h55, 64'h00, 64'hFF};
            db = '{64'h7F, 64'h01, 64'h4A, 64'h55, 64'h00, 64'h00};
            mask = (longint'(1) << WW) - 1;
            repeat (3) @(posedge clk);
            #1;
            rst_l = 1'b0;

            for (int i = 0; i < 6; i++) begin
                send_word(da[i] & mask, db[i] & mask, 0, N);
                idle(2);
            end

            for (int i = 0; i < 30; i++) begin
                wa = longint'($urandom) & mask;
                wb = rand_b(wa);
                send_word(wa, wb, 5, N);
                if (i % 4 != 3) idle($urandom_range(0, 3));
            end
            idle(2);

            for (int i = 0; i < 12; i++) begin
                wa = longint'($urandom) & mask;
                wb = rand_b(wa);
                send_word(wa, wb, 0, N);
            end
            idle(3);

            if (N >= 2) begin
                int k;
                k = (N - 1 < 3) ? N - 1 : 3;
                wa = longint'($urandom) & mask;
                send_word(wa, ~wa & mask, 0, k);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                rst_l    = 1'b1;
                @(negedge clk);
                check(gi, "busy_mid_word", int'(busy), 1);
                @(posedge clk);
                #1;
                rst_l = 1'b0;
                @(negedge clk);
                check(gi, "busy_after_rst", int'(busy), 0);
                for (int i = 0; i < 3; i++) begin
                    wa = longint'($urandom) & mask;
                    wb = rand_b(wa);
                    send_word(wa, wb, 2, N);
                end
            end

            idle(4);
            check(gi, "queue_drained", exp_q.size(), 0);
            done_count++;
        end
    end

    initial begin
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            if (done_count == NCFG) break;
        end
        if (done_count != NCFG) begin
            tests_run++;
            tests_fail++;
            $display("FAIL timeout: %0d of %0d configs finished", done_count, NCFG);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
